// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP classifier sequencer and the MLP instance it drives:
// state encoding, default geometry and counter widths.
package mlp_pkg;

   localparam int WIDTH_DEF      = 8;
   localparam int OL_NEURONS_DEF = 10;
   localparam int ACT_W_DEF      = 4 * WIDTH_DEF;
   localparam int TIMEOUT_DEF    = 65535;

   localparam int CNT_W = 16;
   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_SCAN   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   function automatic int act_w(input int width);
      return 4 * width;
   endfunction

endpackage

// File: rtl/mlp_argmax_step.sv
// One step of the argmax reduction: signed compare of a candidate against the running best.
module mlp_argmax_step
   import mlp_pkg::*;
#(
   parameter int ACT_W = ACT_W_DEF
) (
   input  logic signed [ACT_W-1:0] cand_val,
   input  logic        [IDX_W-1:0] cand_idx,
   input  logic signed [ACT_W-1:0] best_val,
   input  logic        [IDX_W-1:0] best_idx,
   output logic signed [ACT_W-1:0] next_best_val,
   output logic        [IDX_W-1:0] next_best_idx
);

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      next_best_val = best_val;
      next_best_idx = best_idx;
      // Strictly greater only, so a tie keeps the earlier (lower) index.
      if (cand_val > best_val) begin
         next_best_val = cand_val;
         next_best_idx = cand_idx;
      end
   end

endmodule

// File: rtl/mlp_sequencer.sv
// Launches one MLP inference per accepted start, waits (with timeout) for completion,
// then scans a captured copy of the output layer for the winning digit.
module mlp_sequencer
   import mlp_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int OL_neurons     = OL_NEURONS_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic                             busy,
   output logic                             mlp_go,
   input  logic                             mlp_done,
   input  logic [act_w(WIDTH)*OL_neurons-1:0] output_activations,
   output logic [3:0]                       digit,
   output logic [act_w(WIDTH)-1:0]          max_activation,
   output logic                             digit_valid,
   output logic                             timeout_err
);

   localparam int ACT_W = act_w(WIDTH);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] SCAN_LAST    = IDX_W'(OL_neurons - 1);

   state_t                             state_q;
   logic [CNT_W-1:0]                   wait_cnt_q;
   logic [IDX_W-1:0]                   scan_idx_q;
   logic [OL_neurons-1:0][ACT_W-1:0]   acts_q;
   logic signed [ACT_W-1:0]            best_val_q;
   logic [IDX_W-1:0]                   best_idx_q;

   logic                               busy_q;
   logic                               mlp_go_q;
   logic                               digit_valid_q;
   logic                               timeout_err_q;
   logic [3:0]                         digit_q;
   logic [ACT_W-1:0]                   max_act_q;

   logic signed [ACT_W-1:0]            cand_val;
   logic signed [ACT_W-1:0]            best_val_d;
   logic [IDX_W-1:0]                   best_idx_d;

   assign cand_val = acts_q[scan_idx_q];

   mlp_argmax_step #(
      .ACT_W (ACT_W)
   ) u_argmax_step (
      .cand_val      (cand_val),
      .cand_idx      (scan_idx_q),
      .best_val      (best_val_q),
      .best_idx      (best_idx_q),
      .next_best_val (best_val_d),
      .next_best_idx (best_idx_d)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= '0;
         scan_idx_q    <= '0;
         // NOTE: the capture register is reset as well, so a run aborted by reset
         // leaves no stale activations behind.
         acts_q        <= '0;
         best_val_q    <= '0;
         best_idx_q    <= '0;
         busy_q        <= 1'b0;
         mlp_go_q      <= 1'b0;
         digit_valid_q <= 1'b0;
         timeout_err_q <= 1'b0;
         digit_q       <= '0;
         max_act_q     <= '0;
      end else begin
         mlp_go_q      <= 1'b0;
         digit_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_LAUNCH;
                  busy_q        <= 1'b1;
                  mlp_go_q      <= 1'b1;
                  timeout_err_q <= 1'b0;
               end
            end

            S_LAUNCH: begin
               state_q    <= S_WAIT;
               wait_cnt_q <= '0;
            end

            S_WAIT: begin
               // Completion is checked first so it beats a timeout in the same cycle.
               if (mlp_done) begin
                  acts_q     <= output_activations;
                  best_val_q <= output_activations[ACT_W-1:0];
                  best_idx_q <= '0;
                  scan_idx_q <= IDX_W'(1);
                  state_q    <= S_SCAN;
               end else if (wait_cnt_q == TIMEOUT_LAST) begin
                  state_q       <= S_IDLE;
                  busy_q        <= 1'b0;
                  timeout_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end

            S_SCAN: begin
               best_val_q <= best_val_d;
               best_idx_q <= best_idx_d;
               if (scan_idx_q == SCAN_LAST) begin
                  digit_q       <= best_idx_d;
                  max_act_q     <= best_val_d;
                  digit_valid_q <= 1'b1;
                  state_q       <= S_DONE;
               end else begin
                  scan_idx_q <= scan_idx_q + IDX_W'(1);
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign mlp_go         = mlp_go_q;
   assign digit_valid    = digit_valid_q;
   assign timeout_err    = timeout_err_q;
   assign digit          = digit_q;
   assign max_activation = max_act_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench: table-driven argmax vectors through a scoreboard, plus timeout,
// protocol-robustness, back-to-back and reset-mid-scan sequences.
module tb_mlp_sequencer;

   localparam int NN = 10;
   localparam int AW = 32;

   typedef logic [NN-1:0][AW-1:0] acts_t;
   typedef struct packed {
      acts_t       acts;
      logic [3:0]  digit;
      logic [31:0] maxv;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 1: default timeout
   logic        reset1 = 1'b1, start1 = 1'b0, mlp_done1 = 1'b0;
   acts_t       acts1 = '0;
   logic        busy1, go1, dv1, terr1;
   logic [3:0]  digit1;
   logic [31:0] max1;

   // Instance 2: short timeout
   logic        reset2 = 1'b1, start2 = 1'b0, mlp_done2 = 1'b0;
   acts_t       acts2 = '0;
   logic        busy2, go2, dv2, terr2;
   logic [3:0]  digit2;
   logic [31:0] max2;

   mlp_sequencer dut1 (
      .clk(clk), .reset(reset1), .start(start1), .busy(busy1), .mlp_go(go1),
      .mlp_done(mlp_done1), .output_activations(acts1), .digit(digit1),
      .max_activation(max1), .digit_valid(dv1), .timeout_err(terr1)
   );

   mlp_sequencer #(.TIMEOUT_CYCLES(16)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .mlp_go(go2),
      .mlp_done(mlp_done2), .output_activations(acts2), .digit(digit2),
      .max_activation(max2), .digit_valid(dv2), .timeout_err(terr2)
   );

   int total = 0;
   int bad   = 0;
   int go_cnt1 = 0, dv_cnt1 = 0, go_cnt2 = 0, dv_cnt2 = 0;
   vec_t sb1[$];
   vec_t sb2[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic acts_t fill(input logic [31:0] v);
      acts_t a;
      for (int k = 0; k < NN; k++) a[k] = v;
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors sample away from the active edge.
   always @(negedge clk) begin
      if (go1) go_cnt1++;
      if (dv1) begin
         dv_cnt1++;
         if (sb1.size() == 0) check("dut1_unexpected_valid", 64'd1, 64'd0);
         else begin
            vec_t e;
            e = sb1.pop_front();
            check("dut1_digit", digit1, e.digit);
            check("dut1_max_activation", max1, e.maxv);
         end
      end
   end

   always @(negedge clk) begin
      if (go2) go_cnt2++;
      if (dv2) begin
         dv_cnt2++;
         if (sb2.size() == 0) check("dut2_unexpected_valid", 64'd1, 64'd0);
         else begin
            vec_t e;
            e = sb2.pop_front();
            check("dut2_digit", digit2, e.digit);
            check("dut2_max_activation", max2, e.maxv);
         end
      end
   end

   task automatic wait_dv1(output int n);
      n = 1;
      while (!dv1 && n < 60) begin
         tick();
         n++;
      end
   endtask

   // Full run on instance 1: mlp_done arrives done_dly cycles after mlp_go.
   task automatic run_vec(input vec_t v, input int done_dly);
      int n;
      acts1 = v.acts;
      sb1.push_back(v);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("go_at_T_plus_1", go1, 1);
      repeat (done_dly) tick();
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      wait_dv1(n);
      check("valid_latency_after_done", n, NN);
      tick();
      check("valid_is_one_cycle", dv1, 0);
      check("digit_holds", digit1, v.digit);
      check("idle_after_done", busy1, 0);
   endtask

   initial begin
      int n, g0, d0;

      vecs[0].acts = fill(32'd0);
      vecs[0].acts[0] = -32'sd5;
      vecs[0].acts[3] = 32'd1200;
      vecs[0].digit = 4'd3; vecs[0].maxv = 32'd1200;

      vecs[1].acts = fill(-32'sd7);
      vecs[1].digit = 4'd0; vecs[1].maxv = -32'sd7;

      vecs[2].acts = fill(32'd0);
      vecs[2].acts[2] = 32'h7FFF_FFFF;
      vecs[2].acts[8] = 32'h7FFF_FFFF;
      vecs[2].digit = 4'd2; vecs[2].maxv = 32'h7FFF_FFFF;

      vecs[3].acts = fill(32'd50);
      vecs[3].acts[9] = 32'd100;
      vecs[3].digit = 4'd9; vecs[3].maxv = 32'd100;

      vecs[4].acts = fill(-32'sd100);
      vecs[4].acts[5] = -32'sd1;
      vecs[4].digit = 4'd5; vecs[4].maxv = -32'sd1;

      vecs[5].acts = fill(-32'sd2);
      vecs[5].acts[0] = 32'hFFFF_FFFF;
      vecs[5].acts[7] = 32'd1;
      vecs[5].digit = 4'd7; vecs[5].maxv = 32'd1;

      // Reset, with start and mlp_done asserted alongside it.
      start1 = 1'b1; mlp_done1 = 1'b1;
      repeat (3) tick();
      check("rst_prio_busy", busy1, 0);
      check("rst_prio_go", go1, 0);
      start1 = 1'b0; mlp_done1 = 1'b0;
      reset1 = 1'b0; reset2 = 1'b0;
      tick();
      check("rst_busy", busy1, 0);
      check("rst_mlp_go", go1, 0);
      check("rst_digit_valid", dv1, 0);
      check("rst_timeout_err", terr1, 0);
      check("rst_digit", digit1, 0);
      check("rst_max_activation", max1, 0);

      // Table-driven runs; the first is the unique-maximum case with a 20-cycle MLP.
      for (int i = 0; i < 6; i++) run_vec(vecs[i], (i == 0) ? 20 : 3 + i);

      // Spurious mlp_done in IDLE, extra starts in WAIT/SCAN, inputs changed in SCAN.
      g0 = go_cnt1;
      d0 = dv_cnt1;
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      check("spurious_done_busy", busy1, 0);
      check("spurious_done_go", go1, 0);
      acts1 = vecs[0].acts;
      sb1.push_back(vecs[0]);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (3) tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (2) tick();
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      start1 = 1'b1;
      acts1 = fill(32'h7FFF_0000);
      tick();
      start1 = 1'b0;
      acts1[6] = 32'h7FFF_FFFF;
      wait_dv1(n);
      check("robust_valid_seen", dv1, 1);
      repeat (6) tick();
      check("robust_one_go_per_start", go_cnt1 - g0, 1);
      check("robust_one_valid", dv_cnt1 - d0, 1);

      // Back-to-back with start held high across the whole first run.
      acts1 = vecs[1].acts;
      sb1.push_back(vecs[1]);
      sb1.push_back(vecs[2]);
      start1 = 1'b1;
      tick();
      check("b2b_first_go", go1, 1);
      repeat (3) tick();
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      wait_dv1(n);
      check("b2b_first_valid", dv1, 1);
      acts1 = vecs[2].acts;
      tick();
      check("b2b_idle_gap_busy", busy1, 0);
      check("b2b_idle_gap_go", go1, 0);
      tick();
      check("b2b_second_go", go1, 1);
      start1 = 1'b0;
      repeat (2) tick();
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      wait_dv1(n);
      check("b2b_second_valid", dv1, 1);
      tick();

      // Reset on the 4th SCAN cycle.
      acts1 = vecs[4].acts;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (2) tick();
      mlp_done1 = 1'b1;
      tick();
      mlp_done1 = 1'b0;
      repeat (3) tick();
      reset1 = 1'b1;
      d0 = dv_cnt1;
      g0 = go_cnt1;
      tick();
      reset1 = 1'b0;
      check("midscan_rst_busy", busy1, 0);
      check("midscan_rst_go", go1, 0);
      check("midscan_rst_valid", dv1, 0);
      check("midscan_rst_terr", terr1, 0);
      check("midscan_rst_digit", digit1, 0);
      check("midscan_rst_max", max1, 0);
      repeat (15) tick();
      check("midscan_no_valid_after", dv_cnt1 - d0, 0);
      check("midscan_no_go_after", go_cnt1 - g0, 0);
      run_vec(vecs[3], 4);

      // Timeout on the short-timeout instance.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("to_go", go2, 1);
      n = 0;
      while (busy2 && n < 100) begin
         tick();
         n++;
      end
      check("to_cycles_to_idle", n, 17);
      check("to_err_set", terr2, 1);
      check("to_no_valid", dv_cnt2, 0);
      check("to_digit_unchanged", digit2, 0);
      check("to_max_unchanged", max2, 0);
      repeat (3) tick();
      mlp_done2 = 1'b1;
      tick();
      mlp_done2 = 1'b0;
      check("to_err_sticky", terr2, 1);
      check("to_idle_ignores_done", busy2, 0);

      // mlp_done in the very cycle the timeout is reached wins; start clears the flag.
      acts2 = vecs[4].acts;
      sb2.push_back(vecs[4]);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("to_err_cleared_by_start", terr2, 0);
      repeat (16) tick();
      mlp_done2 = 1'b1;
      tick();
      mlp_done2 = 1'b0;
      check("done_wins_no_err", terr2, 0);
      check("done_wins_busy", busy2, 1);
      n = 1;
      while (!dv2 && n < 60) begin
         tick();
         n++;
      end
      check("done_wins_valid_latency", n, NN);
      tick();
      check("done_wins_valid_count", dv_cnt2, 1);

      repeat (3) tick();
      check("sb1_drained", sb1.size(), 0);
      check("sb2_drained", sb2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: base width; each activation is ACT_W = 4*WIDTH bits, signed two's complement.
REQ-002 Parameter OL_neurons, default 10: number of output activations scanned.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum WAIT cycles before abort.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: classification request; sampled only in IDLE.
REQ-007 Port busy, output, 1: high in every state except IDLE.
REQ-008 Port mlp_go, output, 1: one-cycle launch pulse to the MLP.
REQ-009 Port mlp_done, input, 1: MLP completion pulse.
REQ-010 Port output_activations, input, ACT_W*OL_neurons: neuron k occupies bits [k*ACT_W +: ACT_W].
REQ-011 Port digit, output, 4: index of the winning neuron.
REQ-012 Port max_activation, output, ACT_W: signed value of the winning neuron.
REQ-013 Port digit_valid, output, 1: one-cycle pulse when digit and max_activation update.
REQ-014 Port timeout_err, output, 1: sticky abort flag.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT, SCAN, DONE.
REQ-016 IDLE: start=1 moves to LAUNCH next cycle and clears timeout_err.
REQ-017 LAUNCH: mlp_go=1 for exactly this one cycle, then WAIT; mlp_go is 0 in all other states.
REQ-018 WAIT: a 16-bit counter, cleared on entry, increments each cycle.
REQ-019 WAIT exit on mlp_done: capture all OL_neurons activations into an internal register, set best_val=act[0], best_idx=0, scan_idx=1, and go to SCAN.
REQ-020 WAIT exit on timeout: when the counter reaches TIMEOUT_CYCLES-1 with mlp_done=0, go to IDLE and set timeout_err=1.
REQ-021 On a timeout, digit_valid stays 0 and digit and max_activation are unchanged.
REQ-022 If mlp_done=1 in the same cycle the timeout is reached, mlp_done wins.
REQ-023 SCAN: each cycle compare captured act[scan_idx] against best_val as signed values.
REQ-024 SCAN update rule: on strictly greater, load best_val and best_idx; ties keep the lower index.
REQ-025 SCAN duration: after the comparison with scan_idx=OL_neurons-1, go to DONE; SCAN lasts OL_neurons-1 cycles.
REQ-026 DONE: load digit=best_idx and max_activation=best_val, pulse digit_valid=1 for one cycle, return to IDLE.
REQ-027 Latency: with start accepted at cycle T, mlp_go is at T+1; with mlp_done at cycle D, digit_valid is at D+OL_neurons.
REQ-028 SCAN operates only on the captured copy; changes on output_activations after capture have no effect.
REQ-029 start while busy is ignored (not queued); mlp_done outside WAIT is ignored.
REQ-030 Back-to-back: start held high through DONE is accepted in the following IDLE cycle; minimum 1 IDLE cycle between runs.
REQ-031 digit, max_activation and timeout_err hold their values between updates.

Reset
REQ-032 reset=1 forces IDLE on the next edge from any state, including mid-WAIT and mid-SCAN; no mlp_go or digit_valid is issued afterwards for the aborted run.
REQ-033 Reset values: busy=0, mlp_go=0, digit_valid=0, timeout_err=0, digit=0, max_activation=0, WAIT counter=0, scan_idx=0, captured activations=0.
REQ-034 reset has priority over start and mlp_done in the same cycle.

Structure
REQ-035 Shared package/header mlp_pkg holds the state encoding, ACT_W and the OL_neurons and WIDTH defaults shared with the MLP instance.
REQ-036 One sub-module, mlp_argmax_step, holds the combinational signed compare/select (inputs cand_val, cand_idx, best_val, best_idx; outputs next best); FSM, counters and registers stay in mlp_sequencer.

Verification
REQ-037 Scenario 1, unique maximum: activations {0:-5, 3:1200, others 0}, mlp_done 20 cycles after mlp_go -> digit=3, max_activation=1200, digit_valid exactly 10 cycles after mlp_done.
REQ-038 Scenario 2, ties and negatives: all activations = -7 -> digit=0; activations 2 and 8 both equal 0x7FFFFFFF -> digit=2.
REQ-039 Scenario 3, timeout: TIMEOUT_CYCLES=16, mlp_done never asserted -> timeout_err=1 after 16 WAIT cycles, busy=0, no digit_valid; next start clears timeout_err.
REQ-040 Scenario 4, protocol robustness: start pulses during WAIT and SCAN and spurious mlp_done in IDLE -> exactly one mlp_go per accepted start; input activations changed during SCAN do not alter the result.
REQ-041 Scenario 5, reset mid-SCAN: reset at the 4th SCAN cycle -> all outputs at reset values next cycle, no digit_valid; a subsequent run (winner at index 9) gives digit=9.
